spectral_peak_finder: RTL and testbench

Consumes the 48-bit magnitude-squared FFT bin stream that pitch_detect computes from the fft output, one frame of FFT_LEN bins at a time. Tracks the largest magnitude within a configurable bin search window and emits one 24-bit peak bin index per frame. The index is the pitch estimate handed to the phase vocoder stage. Frame boundaries come from an internal bin counter, cross-checked against the input's last flag.

---
 rtl/pitch_pkg.sv | 14 +
 rtl/axis_if.sv | 10 +
 rtl/peak_tracker.sv | 55 +++++
 rtl/spectral_peak_finder.sv | 120 ++++++++++++
 tb/tb_spectral_peak_finder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pitch_pkg.sv
// Shared types and default sizing for the pitch-detect magnitude path.
package pitch_pkg;
  localparam int FFT_LEN_DEF = 1024;
  localparam int MAG_W_DEF   = 48;
  localparam int OUT_W_DEF   = 24;
  localparam int BIN_W_DEF   = $clog2(FFT_LEN_DEF);

  typedef logic [BIN_W_DEF-1:0] bin_idx_t;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;
endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style link: data/valid/ready/last.
interface Axis_If #(parameter int W = 8) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;

  modport Master (output data, output valid, output last, input ready);
  modport Slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/peak_tracker.sv
// Windowed max/argmax register pair; clear has priority over update.
// SPECTRAL_PEAK_NOISE_GATE_EN forces the reported index to 0 below GATE_THRESH.
module peak_tracker
  import pitch_pkg::*;
#(
  parameter int MAG_W   = MAG_W_DEF,
  parameter int IDX_W   = BIN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int MIN_BIN = 2
`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
  , parameter logic [MAG_W-1:0] GATE_THRESH = MAG_W'(64'd1 << 20)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [MAG_W-1:0] mag_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [OUT_W-1:0] result_o
);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(MIN_BIN);

  logic [MAG_W-1:0] max_mag_q, max_mag_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;

  always_comb begin
    max_mag_d = max_mag_q;
    max_idx_d = max_idx_q;
    if (clr_i) begin
      max_mag_d = '0;
      max_idx_d = IDX_INIT;
    end else if (upd_i && (mag_i > max_mag_q)) begin
      // Strict compare: on ties the earlier (lower) bin is kept.
      max_mag_d = mag_i;
      max_idx_d = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag_q <= '0;
      max_idx_q <= IDX_INIT;
    end else begin
      max_mag_q <= max_mag_d;
      max_idx_q <= max_idx_d;
    end
  end

`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
  assign result_o = (max_mag_q < GATE_THRESH) ? '0 : OUT_W'(max_idx_q);
`else
  assign result_o = OUT_W'(max_idx_q);
`endif
endmodule

// File: rtl/spectral_peak_finder.sv
// Per-frame argmax of FFT bin magnitudes inside [MIN_BIN, MAX_BIN]; one index out per frame.
// Optional unvoiced gating via SPECTRAL_PEAK_NOISE_GATE_EN.
module spectral_peak_finder
  import pitch_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int MIN_BIN = 2,
  parameter int MAX_BIN = 511,
  parameter int MAG_W   = MAG_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
  , parameter logic [MAG_W-1:0] GATE_THRESH = MAG_W'(64'd1 << 20)
`endif
) (
  input  logic   clk,
  input  logic   reset,
  Axis_If.Slave  fft_mag,
  Axis_If.Master dout,
  output logic   frame_err
);
  localparam int BIN_W = $clog2(FFT_LEN);
  localparam logic [BIN_W-1:0] WIN_LO   = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] WIN_HI   = BIN_W'(MAX_BIN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             mag_rdy_q, mag_rdy_d;
  logic             dout_vld_q, dout_vld_d;
  logic             frame_err_q, frame_err_d;
  logic             trk_clr, trk_upd;
  logic [OUT_W-1:0] peak_idx;

  logic beat, in_window, final_bin;
  assign beat      = fft_mag.valid & mag_rdy_q;
  assign in_window = (bin_cnt_q >= WIN_LO) && (bin_cnt_q <= WIN_HI);
  assign final_bin = (bin_cnt_q == LAST_BIN);

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    mag_rdy_d   = mag_rdy_q;
    dout_vld_d  = dout_vld_q;
    frame_err_d = 1'b0;
    trk_clr     = 1'b0;
    trk_upd     = 1'b0;
    unique case (state_q)
      ACCUM: begin
        mag_rdy_d = 1'b1;
        if (beat) begin
          trk_upd = in_window;
          if (final_bin) begin
            bin_cnt_d   = '0;
            state_d     = EMIT;
            dout_vld_d  = 1'b1;
            mag_rdy_d   = 1'b0;
            frame_err_d = ~fft_mag.last;
          end else if (fft_mag.last) begin
            // Short frame: drop it and restart the search from bin 0.
            bin_cnt_d   = '0;
            trk_clr     = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            bin_cnt_d = bin_cnt_q + BIN_W'(1);
          end
        end
      end
      EMIT: begin
        mag_rdy_d = 1'b0;
        if (dout_vld_q && dout.ready) begin
          dout_vld_d = 1'b0;
          trk_clr    = 1'b1;
          state_d    = ACCUM;
          mag_rdy_d  = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      bin_cnt_q   <= '0;
      mag_rdy_q   <= 1'b0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      mag_rdy_q   <= mag_rdy_d;
      dout_vld_q  <= dout_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  peak_tracker #(
    .MAG_W   (MAG_W),
    .IDX_W   (BIN_W),
    .OUT_W   (OUT_W),
    .MIN_BIN (MIN_BIN)
`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
    , .GATE_THRESH (GATE_THRESH)
`endif
  ) u_peak_tracker (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (trk_clr),
    .upd_i    (trk_upd),
    .mag_i    (fft_mag.data),
    .idx_i    (bin_cnt_q),
    .result_o (peak_idx)
  );

  assign fft_mag.ready = mag_rdy_q;
  assign dout.valid    = dout_vld_q;
  assign dout.data     = dout_vld_q ? peak_idx : '0;
  assign dout.last     = 1'b1;
  assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_spectral_peak_finder.sv
// Directed bench for spectral_peak_finder with a 16-bin frame and window [1,7].
module tb_spectral_peak_finder;
  localparam int FFT_LEN = 16;
  localparam int MAG_W   = 48;
  localparam int OUT_W   = 24;
`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic frame_err;
  always #5 clk = ~clk;

  Axis_If #(.W(MAG_W)) mag_if ();
  Axis_If #(.W(OUT_W)) dout_if ();

  spectral_peak_finder #(
    .FFT_LEN (FFT_LEN),
    .MIN_BIN (1),
    .MAX_BIN (7),
    .MAG_W   (MAG_W),
    .OUT_W   (OUT_W)
`ifdef SPECTRAL_PEAK_NOISE_GATE_EN
    , .GATE_THRESH (48'd100)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fft_mag   (mag_if),
    .dout      (dout_if),
    .frame_err (frame_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int beats    = 0;
  int errs     = 0;
  logic [MAG_W-1:0] frm [FFT_LEN];

  always @(negedge clk) begin
    if (!reset && dout_if.valid && dout_if.ready) beats++;
    if (frame_err) errs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [MAG_W-1:0] v);
    for (int i = 0; i < FFT_LEN; i++) frm[i] = v;
  endtask

  // Drive one bin at a negedge; it transfers on the next posedge once ready is seen high.
  task automatic send_bin(input logic [MAG_W-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    mag_if.valid = 1'b1;
    mag_if.data  = d;
    mag_if.last  = l;
    while (!mag_if.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!mag_if.ready) chk("accept_timeout", 64'(mag_if.ready), 64'd1);
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_bin(frm[i], (i == last_at));
  endtask

  task automatic expect_result(input string tag, input logic [OUT_W-1:0] exp);
    @(negedge clk);
    mag_if.valid = 1'b0;
    mag_if.last  = 1'b0;
    chk({tag, "_valid"}, 64'(dout_if.valid), 64'd1);
    chk({tag, "_data"}, 64'(dout_if.data), 64'(exp));
    chk({tag, "_in_stall"}, 64'(mag_if.ready), 64'd0);
    if (dout_if.ready) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, 64'(dout_if.valid), 64'd0);
      chk({tag, "_in_resume"}, 64'(mag_if.ready), 64'd1);
    end
  endtask

  initial begin
    int e0, b0;
    bit ok;
    reset         = 1'b1;
    mag_if.valid  = 1'b0;
    mag_if.data   = '0;
    mag_if.last   = 1'b0;
    dout_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", 64'(dout_if.valid), 64'd0);
    chk("rst_dout_data", 64'(dout_if.data), 64'd0);
    chk("rst_in_ready", 64'(mag_if.ready), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(mag_if.ready), 64'd1);

    // Single peak, plus one-cycle latency from the final beat.
    fill(5); frm[4] = 1000;
    send_frame(16, 15);
    chk("single_pre_valid", 64'(dout_if.valid), 64'd0);
    expect_result("single", 4);
    chk("single_no_err", 64'(errs), 64'd0);
    chk("single_beats", 64'(beats), 64'd1);

    // Out-of-window giants ignored, equal in-window peaks resolve to the lowest bin.
    fill(1); frm[0] = 9999; frm[9] = 9999; frm[2] = 500; frm[6] = 500;
    send_frame(16, 15);
    expect_result("window_tie", 2);

    // Tie between both window edges; bin 8 just outside is larger.
    fill(2); frm[1] = 300; frm[7] = 300; frm[8] = 88888;
    send_frame(16, 15);
    expect_result("edge_tie", 1);

    // Output backpressure for 20 cycles.
    dout_if.ready = 1'b0;
    fill(2); frm[7] = 77777; frm[8] = 88888; frm[15] = 99999;
    send_frame(16, 15);
    @(negedge clk);
    mag_if.valid = 1'b0;
    mag_if.last  = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      if (!(dout_if.valid === 1'b1 && dout_if.data === 24'd7 && mag_if.ready === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_hold_stable", 64'(ok), 64'd1);
    chk("bp_data", 64'(dout_if.data), 64'd7);
    dout_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(dout_if.valid), 64'd0);
    chk("bp_release_ready", 64'(mag_if.ready), 64'd1);

    // All-zero frame reports MIN_BIN (or unvoiced when gated).
    fill(0);
    send_frame(16, 15);
    expect_result("degenerate", GATED ? 24'd0 : 24'd1);

    // Final beat without last still completes, flagged once.
    e0 = errs;
    fill(3); frm[6] = 400;
    send_frame(16, -1);
    expect_result("missing_last", 6);
    chk("missing_last_err", 64'(errs), 64'(e0 + 1));

    // Early last aborts the frame and clears the tracked peak.
    e0 = errs; b0 = beats;
    fill(5); frm[5] = 5000;
    send_frame(10, 9);
    @(negedge clk);
    mag_if.valid = 1'b0;
    mag_if.last  = 1'b0;
    chk("early_err_pulse", 64'(frame_err), 64'd1);
    chk("early_no_valid", 64'(dout_if.valid), 64'd0);
    chk("early_ready", 64'(mag_if.ready), 64'd1);
    @(negedge clk);
    chk("early_err_drop", 64'(frame_err), 64'd0);
    fill(5); frm[3] = 1000;
    send_frame(16, 15);
    expect_result("after_early", 3);
    chk("early_err_count", 64'(errs), 64'(e0 + 1));
    chk("early_beats", 64'(beats), 64'(b0 + 1));

    // Reset while bin 7 is on the bus discards the partial frame.
    b0 = beats;
    fill(5); frm[2] = 7000;
    send_frame(7, -1);
    @(negedge clk);
    reset        = 1'b1;
    mag_if.data  = 48'd5;
    @(negedge clk);
    mag_if.valid = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(mag_if.ready), 64'd0);
    chk("midrst_valid", 64'(dout_if.valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    fill(5); frm[5] = 1000;
    send_frame(16, 15);
    expect_result("after_rst", 5);
    chk("after_rst_beats", 64'(beats), 64'(b0 + 1));

    // Threshold boundary: 99 sits below a gate of 100, 100 does not.
    fill(1); frm[3] = 99;
    send_frame(16, 15);
    expect_result("gate_below", GATED ? 24'd0 : 24'd3);
    fill(1); frm[3] = 100;
    send_frame(16, 15);
    expect_result("gate_at", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
